// File: rtl/bsnet_pkg.sv
// Shared types and helpers for the bitstream network blocks.
package bsnet_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } bsdec_state_t;

  function automatic int count_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/bitstream_decoder_ones_counter.sv
// Per-channel ones counter: synchronous clear has priority over counting.
module ones_counter #(
  parameter int COUNT_W = 5
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               clr,
  input  logic               en,
  input  logic               bit_in,
  output logic [COUNT_W-1:0] count
);

  logic [COUNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (en && bit_in)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (n_rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/bitstream_decoder.sv
// Bitstream-to-binary decoder: counts ones per channel over a window of valid samples.
// Optional back-to-back windowing via BITSTREAM_DECODER_CONTINUOUS_EN.
module bitstream_decoder
  import bsnet_pkg::*;
#(
  parameter int NUM_CH     = 2,
  parameter int WINDOW_LEN = 16,
  parameter int COUNT_W    = count_width(WINDOW_LEN)
) (
  input  logic                      clk,
  input  logic                      n_rst,
  input  logic [NUM_CH-1:0]         bit_in,
  input  logic                      bit_valid,
  input  logic                      start,
  output logic [NUM_CH*COUNT_W-1:0] value_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      overrun
);

  localparam int SAMP_W = $clog2(WINDOW_LEN);

  bsdec_state_t              state_q, state_d;
  logic [SAMP_W-1:0]         samp_q, samp_d;
  logic [NUM_CH*COUNT_W-1:0] value_q, value_d;
  logic                      out_valid_q, out_valid_d;
  logic                      cnt_clr, cnt_en;
  logic                      window_done;
  logic [NUM_CH*COUNT_W-1:0] final_cnt;
  logic [COUNT_W-1:0]        cnt [NUM_CH];

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    ones_counter #(
      .COUNT_W(COUNT_W)
    ) u_cnt (
      .clk   (clk),
      .n_rst (n_rst),
      .clr   (cnt_clr),
      .en    (cnt_en),
      .bit_in(bit_in[k]),
      .count (cnt[k])
    );
  end

`ifdef BITSTREAM_DECODER_CONTINUOUS_EN
  logic overrun_q, overrun_d;
`endif

  always_comb begin
    state_d     = state_q;
    samp_d      = samp_q;
    value_d     = value_q;
    out_valid_d = out_valid_q;
    cnt_clr     = 1'b0;
    cnt_en      = 1'b0;
`ifdef BITSTREAM_DECODER_CONTINUOUS_EN
    overrun_d   = overrun_q;
`endif

    window_done = (state_q == ACCUM) && bit_valid &&
                  (samp_q == SAMP_W'(WINDOW_LEN - 1));
    // Result includes the completing sample, which the counters have not yet absorbed.
    final_cnt = '0;
    for (int unsigned k = 0; k < NUM_CH; k++)
      final_cnt[k*COUNT_W +: COUNT_W] = cnt[k] + COUNT_W'(bit_in[k]);

    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_clr = 1'b1;
          samp_d  = '0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (bit_valid) begin
          cnt_en = 1'b1;
          samp_d = samp_q + 1'b1;
          if (window_done) begin
            samp_d = '0;
`ifdef BITSTREAM_DECODER_CONTINUOUS_EN
            cnt_clr = 1'b1;
`else
            value_d     = final_cnt;
            out_valid_d = 1'b1;
            state_d     = DONE;
`endif
          end
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (start) begin
            cnt_clr = 1'b1;
            samp_d  = '0;
            state_d = ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef BITSTREAM_DECODER_CONTINUOUS_EN
    // Output register runs independently of accumulation; a full unaccepted slot drops the new result.
    if (out_valid_q && out_ready)
      out_valid_d = 1'b0;
    if (window_done) begin
      if (!out_valid_q || out_ready) begin
        value_d     = final_cnt;
        out_valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (n_rst) begin
      state_q     <= IDLE;
      samp_q      <= '0;
      value_q     <= '0;
      out_valid_q <= 1'b0;
`ifdef BITSTREAM_DECODER_CONTINUOUS_EN
      overrun_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      samp_q      <= samp_d;
      value_q     <= value_d;
      out_valid_q <= out_valid_d;
`ifdef BITSTREAM_DECODER_CONTINUOUS_EN
      overrun_q   <= overrun_d;
`endif
    end
  end

  assign value_out = value_q;
  assign out_valid = out_valid_q;
  assign busy      = (state_q == ACCUM);
`ifdef BITSTREAM_DECODER_CONTINUOUS_EN
  assign overrun   = overrun_q;
`else
  assign overrun   = 1'b0;
`endif

endmodule

// File: tb/tb_bitstream_decoder.sv
// Bench for bitstream_decoder: directed plan plus random traffic against a window-level model.
module tb_bitstream_decoder;

  localparam int NUM_CH = 2;
  localparam int WL     = 16;
  localparam int CW     = $clog2(WL + 1);

  logic                 clk = 1'b0;
  logic                 n_rst;
  logic [NUM_CH-1:0]    bit_in;
  logic                 bit_valid;
  logic                 start;
  logic [NUM_CH*CW-1:0] value_out;
  logic                 out_valid;
  logic                 out_ready;
  logic                 busy;
  logic                 overrun;

  int n_total = 0;
  int n_bad   = 0;

  int                   m_phase;   // 0 idle, 1 accumulating, 2 holding result
  logic                 m_valid;
  logic                 m_overrun;
  logic [NUM_CH*CW-1:0] m_value;
  logic [NUM_CH-1:0]    win_q[$];

  bitstream_decoder #(
    .NUM_CH    (NUM_CH),
    .WINDOW_LEN(WL)
  ) dut (
    .clk      (clk),
    .n_rst    (n_rst),
    .bit_in   (bit_in),
    .bit_valid(bit_valid),
    .start    (start),
    .value_out(value_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NUM_CH*CW-1:0] window_sum();
    logic [NUM_CH*CW-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      int ones;
      ones = 0;
      foreach (win_q[i]) ones += int'(win_q[i][k]);
      r[k*CW +: CW] = CW'(ones);
    end
    return r;
  endfunction

  task automatic model_update();
    logic old_valid;
    if (n_rst) begin
      m_phase = 0; m_valid = 1'b0; m_value = '0; m_overrun = 1'b0;
      win_q.delete();
      return;
    end
`ifdef BITSTREAM_DECODER_CONTINUOUS_EN
    if (m_phase == 0) begin
      if (start) begin m_phase = 1; win_q.delete(); end
    end else begin
      old_valid = m_valid;
      if (m_valid && out_ready) m_valid = 1'b0;
      if (bit_valid) begin
        win_q.push_back(bit_in);
        if (win_q.size() == WL) begin
          if (!old_valid || out_ready) begin
            m_value = window_sum();
            m_valid = 1'b1;
          end else begin
            m_overrun = 1'b1;
          end
          win_q.delete();
        end
      end
    end
`else
    old_valid = m_valid;
    case (m_phase)
      0: if (start) begin m_phase = 1; win_q.delete(); end
      1: if (bit_valid) begin
           win_q.push_back(bit_in);
           if (win_q.size() == WL) begin
             m_value = window_sum();
             m_valid = 1'b1;
             m_phase = 2;
           end
         end
      default: if (out_ready) begin
           m_valid = 1'b0;
           if (start) begin m_phase = 1; win_q.delete(); end
           else m_phase = 0;
         end
    endcase
`endif
  endtask

  task automatic step(input logic r, input logic s, input logic bv, input logic rdy,
                      input logic [NUM_CH-1:0] b);
    n_rst = r; start = s; bit_valid = bv; out_ready = rdy; bit_in = b;
    @(posedge clk);
    model_update();
    #1;
    check_val("out_valid", 64'(out_valid), 64'(m_valid));
    check_val("busy", 64'(busy), 64'(m_phase == 1));
    check_val("value_out", 64'(value_out), 64'(m_value));
    check_val("overrun", 64'(overrun), 64'(m_overrun));
  endtask

  function automatic logic [NUM_CH*CW-1:0] pack2(input int c0, input int c1);
    logic [NUM_CH*CW-1:0] r;
    r = '0;
    r[0 +: CW]  = CW'(c0);
    r[CW +: CW] = CW'(c1);
    return r;
  endfunction

  initial begin
    n_rst = 1'b1; start = 1'b0; bit_valid = 1'b0; out_ready = 1'b0; bit_in = '0;
    m_phase = 0; m_valid = 1'b0; m_overrun = 1'b0; m_value = '0;

    step(1, 0, 0, 0, '0);
    step(1, 1, 1, 1, '1);
    check_val("rst_value", 64'(value_out), 64'(0));
    check_val("rst_valid", 64'(out_valid), 64'(0));
    check_val("rst_busy", 64'(busy), 64'(0));

`ifndef BITSTREAM_DECODER_CONTINUOUS_EN
    // Window of ch0 ones; start cycle sample is not counted.
    step(0, 1, 1, 0, 2'b11);
    for (int i = 0; i < WL; i++) begin
      if (i < WL - 1) begin
        step(0, 0, 1, 0, 2'b01);
        check_val("t1_pending", 64'(out_valid), 64'(0));
      end else begin
        step(0, 0, 1, 0, 2'b01);
      end
    end
    check_val("t1_valid", 64'(out_valid), 64'(1));
    check_val("t1_counts", 64'(value_out), 64'(pack2(16, 0)));
    check_val("t1_busy", 64'(busy), 64'(0));

    // Gapped window: garbage on invalid cycles must not count.
    step(0, 1, 0, 1, 2'b00);
    for (int i = 0; i < 32; i++) begin
      int j;
      logic [1:0] b;
      j = i / 2;
      if (i % 2 == 0) b = {logic'(j % 4 == 0), logic'(j % 2 == 0)};
      else            b = 2'($urandom);
      step(0, 0, logic'(i % 2 == 0), 0, b);
    end
    check_val("t2_counts", 64'(value_out), 64'(pack2(8, 4)));

    // Result held with consumer stalled; start ignored.
    for (int i = 0; i < 10; i++) begin
      step(0, logic'($urandom_range(0, 1)), 1, 0, 2'($urandom));
      check_val("t3_hold", 64'(value_out), 64'(pack2(8, 4)));
    end
    step(0, 1, 0, 1, 2'b00);
    check_val("t3_restart_busy", 64'(busy), 64'(1));
    for (int i = 0; i < WL; i++) step(0, 0, 1, 0, 2'b11);
    check_val("t3_fresh", 64'(value_out), 64'(pack2(16, 16)));

    // Reset at sample 9.
    step(0, 0, 0, 1, 2'b00);
    step(0, 1, 0, 0, 2'b00);
    for (int i = 0; i < 8; i++) step(0, 0, 1, 0, 2'b11);
    step(1, 0, 1, 0, 2'b11);
    check_val("t4_busy", 64'(busy), 64'(0));
    check_val("t4_valid", 64'(out_valid), 64'(0));
    check_val("t4_value", 64'(value_out), 64'(0));
    step(0, 1, 0, 0, 2'b00);
    for (int i = 0; i < WL; i++) step(0, 0, 1, 0, 2'b11);
    check_val("t4_clean", 64'(value_out), 64'(pack2(16, 16)));
    step(0, 0, 0, 1, 2'b00);
`else
    // Two windows with consumer stalled: second result dropped.
    step(0, 1, 0, 0, 2'b00);
    for (int i = 0; i < WL; i++) step(0, 0, 1, 0, 2'b01);
    check_val("c1_first", 64'(value_out), 64'(pack2(16, 0)));
    for (int i = 0; i < WL; i++) step(0, logic'(i == 3), 1, 0, 2'b10);
    check_val("c1_retained", 64'(value_out), 64'(pack2(16, 0)));
    check_val("c1_overrun", 64'(overrun), 64'(1));
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < WL; i++) step(0, 0, 1, 1, 2'($urandom));
      check_val("c2_valid", 64'(out_valid), 64'(1));
    end
    for (int i = 0; i < WL; i++) step(0, 0, 1, 1, 2'b11);
    check_val("c2_counts", 64'(value_out), 64'(pack2(16, 16)));
    check_val("c2_sticky", 64'(overrun), 64'(1));
    step(1, 0, 0, 0, 2'b00);
    check_val("c3_rst_overrun", 64'(overrun), 64'(0));
`endif

    // Random traffic, including occasional resets.
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 299) == 0),
           logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 3) != 0),
           logic'($urandom_range(0, 2) == 0),
           2'($urandom));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bitstream_decoder.md
# bitstream_decoder

Converts the stochastic bitstreams leaving a layer of `neuron` instances back into binary values by counting ones over a fixed window of valid samples. Sits directly downstream of a layer, one channel per neuron output. Each window produces one set of counts delivered through a valid/ready handshake to the readout or host-interface logic.

## Interface
Parameters:
- `NUM_CH`, 2, number of bitstream channels (one per upstream neuron)
- `WINDOW_LEN`, 16, valid samples per conversion window; must be ≥ 2
- `COUNT_W`, `$clog2(WINDOW_LEN+1)`, width of each channel count

Ports:
- `clk`  input  1  the single clock; all logic on its rising edge
- `n_rst`  input  1  synchronous, active-high reset
- `bit_in`  input  `NUM_CH`  one bitstream bit per channel
- `bit_valid`  input  1  `bit_in` is a sample this cycle
- `start`  input  1  request a new conversion window
- `value_out`  output  `NUM_CH*COUNT_W`  channel k count in bits `[k*COUNT_W +: COUNT_W]`
- `out_valid`  output  1  `value_out` holds a completed result
- `out_ready`  input  1  consumer accepts the result
- `busy`  output  1  a window is accumulating
- `overrun`  output  1  sticky: a completed window was dropped

## Operation
- FSM states `IDLE`, `ACCUM`, `DONE`.
- `IDLE`: `start` clears the sample counter and all channel counts, then moves to `ACCUM`. Inputs are ignored without `start`.
- `ACCUM`: each cycle with `bit_valid`, the sample counter increments and each channel count adds `bit_in[k]`. Cycles without `bit_valid` change nothing.
- Window completion is the cycle the `WINDOW_LEN`-th valid sample is taken:
  - Counts including that sample go to the `value_out` register.
  - The FSM moves to `DONE`.
- `DONE`: `out_valid`=1 and `value_out` is held stable until `out_ready`=1.
  - On handshake with `start`=0, the FSM goes to `IDLE`.
  - On handshake with `start`=1 in the same cycle, the FSM goes straight to `ACCUM` with counters cleared.
- `start` in `ACCUM`, or in `DONE` without `out_ready`, is ignored.
- Counts saturate by construction: the maximum is `WINDOW_LEN`, which fits in `COUNT_W`. No wrap is possible.
- The sample counter wraps to 0 on completion.
- `busy` = (state == `ACCUM`).

## Timing
- Reset values: state `IDLE`; `value_out`=0; `out_valid`=0; `busy`=0; `overrun`=0; all counters 0.
- Reset mid-window or mid-`DONE` discards everything; the block is in `IDLE` next cycle.
- `start` sampled in cycle T: `busy`=1 from T+1. A `bit_valid` in cycle T itself is not counted.
- Latency: last sample in cycle T gives `out_valid`=1 in cycle T+1.
- Minimum window is `WINDOW_LEN` cycles with `bit_valid` held high.
- `out_valid` falls the cycle after the accepting handshake unless a new result is loaded in that same edge (continuous mode only).

## Configuration
Macro `BITSTREAM_DECODER_CONTINUOUS_EN`.
- Defined:
  - After the first `start`, windows run back-to-back. Accumulation continues in `ACCUM` while `DONE` behaviour (`out_valid`/`value_out`) runs concurrently from a separate output register.
  - On completion with `out_valid`=0, or with `out_valid`=1 and `out_ready`=1 that cycle, the new result loads and `out_valid`=1.
  - On completion with `out_valid`=1 and `out_ready`=0, the new result is dropped, the old one is kept, and `overrun` sets and holds until reset.
  - `start` is then ignored; only reset returns the block to `IDLE`.
- Undefined:
  - Single-shot behaviour as described above.
  - `overrun` is tied to 0.

## Structure
- Shared package `bsnet_pkg`:
  - typedef `bsdec_state_t` (`IDLE`, `ACCUM`, `DONE`)
  - function `count_width(len)` returning `$clog2(len+1)`
- Sub-module `ones_counter`: one per channel, generated `NUM_CH` times.
  - Ports: `clk`, `n_rst`, `clr`, `en`, `bit_in`, `count[COUNT_W-1:0]`.
  - Behaviour: synchronous clear has priority over increment.
- The top level holds the FSM, sample counter, output register and `overrun` flag.

## Test plan
- Reset, then `start`; `bit_valid`=1 for 16 cycles with `bit_in`=2'b01 every cycle. Required: ch0=16, ch1=0, `out_valid` on cycle 17 after `start`, `busy`=0 after completion.
- Alternating 1/0 on ch0 and 1 in every 4th cycle on ch1, `bit_valid` toggling every other cycle. Required: ch0=8, ch1=4 after 32 cycles; gaps do not count.
- Hold `out_ready`=0 for 10 cycles in `DONE`. Required: `value_out` stable and `start` ignored. Then `out_ready` and `start` together: new window begins with counts 0.
- Assert `n_rst` at sample 9. Required: next cycle in `IDLE` with all outputs 0; a later `start` produces a clean result of 16 for all-ones input.
- With `BITSTREAM_DECODER_CONTINUOUS_EN`: `out_ready`=0 through two windows. Required: first result retained and `overrun`=1 after the second completion. Then `out_ready`=1 across windows: one result per 16 cycles, no further drops.
